// File: rtl/div_sqrt_iter_ctrl.sv
// Radix-2 non-restoring mantissa divide / square-root engine, one result bit per clock.
// Optional build macro DIV_SQRT_EARLY_TERM_EN: finish early when the partial remainder hits zero.
module div_sqrt_iter_ctrl #(
    parameter int WIDTH = 24
) (
    input  logic             Clk_CI,
    input  logic             Rst_RBI,
    input  logic             Div_start_SI,
    input  logic             Sqrt_start_SI,
    input  logic             Sqrt_odd_SI,
    input  logic             Kill_SI,
    input  logic [WIDTH-1:0] Mant_a_DI,
    input  logic [WIDTH-1:0] Mant_b_DI,
    output logic             Ready_SO,
    output logic             Done_SO,
    output logic [WIDTH+1:0] Quot_DO,
    output logic             Sticky_SO,
    output logic             Div_zero_SO
);
    localparam int N  = WIDTH + 2;
    localparam int RW = WIDTH + 4;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, ITER, CORR, FIN} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 is_sqrt_q, is_sqrt_d;
    logic                 div0_q, div0_d;
    logic                 done_q, done_d;
    logic                 sticky_q, sticky_d;
    logic                 divz_q, divz_d;
    logic [N-1:0]         quot_q, quot_d;
    logic signed [RW-1:0] rem_q, rem_d;
    logic [N-1:0]         root_q, root_d;
    logic [2*N-1:0]       rad_q, rad_d;
    logic [WIDTH:0]       dsr_q, dsr_d;

    logic                 accept;
    logic                 rem_neg;
    logic signed [RW-1:0] dsr_ext;
    logic signed [RW-1:0] sqrt_base;
    logic signed [RW-1:0] rem_iter;
    logic signed [RW-1:0] rem_fix;
    logic [N-1:0]         root_iter;

    assign accept    = (state_q == IDLE) && (Div_start_SI || Sqrt_start_SI);
    assign rem_neg   = rem_q[RW-1];
    // Divisor is held as 2B so the first step 2R-2B weighs the quotient bit at 2^0.
    assign dsr_ext   = {{(RW-WIDTH-1){1'b0}}, dsr_q};
    assign sqrt_base = {rem_q[RW-3:0], rad_q[2*N-1 -: 2]};

    always_comb begin
        if (is_sqrt_q) begin
            rem_iter = rem_neg ? sqrt_base + $signed({root_q, 2'b11})
                               : sqrt_base - $signed({root_q, 2'b01});
            rem_fix  = rem_q + $signed({1'b0, root_q, 1'b1});
        end else begin
            rem_iter = rem_neg ? (rem_q <<< 1) + dsr_ext : (rem_q <<< 1) - dsr_ext;
            rem_fix  = rem_q + dsr_ext;
        end
        root_iter = {root_q[N-2:0], ~rem_iter[RW-1]};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_sqrt_d = is_sqrt_q;
        div0_d    = div0_q;
        done_d    = 1'b0;
        quot_d    = quot_q;
        sticky_d  = sticky_q;
        divz_d    = divz_q;
        rem_d     = rem_q;
        root_d    = root_q;
        rad_d     = rad_q;
        dsr_d     = dsr_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    is_sqrt_d = ~Div_start_SI;
                    div0_d    = Div_start_SI & ~Mant_b_DI[WIDTH-1];
                    divz_d    = 1'b0;
                    cnt_d     = '0;
                    rem_d     = Div_start_SI ? {{(RW-WIDTH){1'b0}}, Mant_a_DI} : '0;
                    root_d    = '0;
                    rad_d     = Sqrt_odd_SI ? {Mant_a_DI, {(2*N-WIDTH){1'b0}}}
                                            : {1'b0, Mant_a_DI, {(2*N-WIDTH-1){1'b0}}};
                    dsr_d     = {Mant_b_DI, 1'b0};
                    state_d   = (Div_start_SI && !Mant_b_DI[WIDTH-1]) ? FIN : ITER;
                end
            end
            ITER: begin
                if (Kill_SI) begin
                    state_d = IDLE;
                end else begin
                    rem_d  = rem_iter;
                    root_d = root_iter;
                    rad_d  = {rad_q[2*N-3:0], 2'b00};
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = CORR;
`ifdef DIV_SQRT_EARLY_TERM_EN
                    if (rem_iter == '0) begin
                        root_d  = root_iter << (LAST - cnt_q);
                        state_d = CORR;
                    end
`endif
                end
            end
            CORR: begin
                if (Kill_SI) begin
                    state_d = IDLE;
                end else begin
                    if (rem_neg) rem_d = rem_fix;
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d  = IDLE;
                done_d   = 1'b1;
                quot_d   = div0_q ? '1 : root_q;
                sticky_d = !div0_q && (rem_q != '0);
                divz_d   = div0_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_sqrt_q <= 1'b0;
            div0_q    <= 1'b0;
            done_q    <= 1'b0;
            quot_q    <= '0;
            sticky_q  <= 1'b0;
            divz_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_sqrt_q <= is_sqrt_d;
            div0_q    <= div0_d;
            done_q    <= done_d;
            quot_q    <= quot_d;
            sticky_q  <= sticky_d;
            divz_q    <= divz_d;
        end
    end

    // Datapath registers are always loaded before use, so they carry no reset.
    always_ff @(posedge Clk_CI) begin
        rem_q  <= rem_d;
        root_q <= root_d;
        rad_q  <= rad_d;
        dsr_q  <= dsr_d;
    end

    assign Ready_SO    = (state_q == IDLE);
    assign Done_SO     = done_q;
    assign Quot_DO     = quot_q;
    assign Sticky_SO   = sticky_q;
    assign Div_zero_SO = divz_q;
endmodule
